// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C register target.
// State encoding and byte-framing constants used by the target FSM and datapath.
package i2c_tgt_pkg;
   localparam int BYTE_W = 8;
   localparam int RW_BIT = 0;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      SUB,
      SUB_ACK,
      WR,
      WR_ACK,
      RD,
      RD_ACK,
      IDLE_WAIT
   } state_t;
endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus stability filter for one I2C line.
// Also produces single-cycle rise/fall pulses of the filtered level.
module i2c_line_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line_in,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

   logic [1:0]    sync_r;
   logic [CW-1:0] cnt_r;

   // sync, then accept a new level only after it has held for FILT_LEN cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_r <= 2'b11;
         cnt_r  <= CW'(0);
         level  <= 1'b1;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_r <= {sync_r[0], line_in};
         rise   <= 1'b0;
         fall   <= 1'b0;
         if (sync_r[1] == level) begin
            cnt_r <= CW'(0);
         end else if (cnt_r == CNT_MAX) begin
            cnt_r <= CW'(0);
            level <= sync_r[1];
            rise  <= sync_r[1];
            fall  <= ~sync_r[1];
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end
   end
endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with a 256x8 register file and auto-incrementing sub-address.
// SDA is open-drain; all line inputs are oversampled and filtered on iCLK.
module i2c_reg_target
   import i2c_tgt_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h39,
   parameter int         FILT_LEN = 3
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       I2C_SCL,
   inout  wire        I2C_SDA,
   input  logic [7:0] host_addr,
   output logic [7:0] host_rdata,
   output logic       wr_stb,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy
);
   localparam logic [3:0] LAST_BIT = 4'(BYTE_W - 1);
   localparam logic [3:0] ACK_BIT  = 4'(BYTE_W);

   logic scl_lvl_s, scl_rise_s, scl_fall_s;
   logic sda_lvl_s, sda_rise_s, sda_fall_s;
   logic start_s, stop_s, last_rise_s, ack_done_s;
   logic [7:0] in_byte_s, rd_byte_s;

   state_t     state_r, next_state;
   logic [3:0] bit_cnt_r;
   logic [7:0] shift_r, sub_r;
   logic       rw_r, nack_r, sda_oe_r;
   logic [7:0] regs_r [256];

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk(iCLK), .rst_n(iRST_N), .line_in(I2C_SCL),
      .level(scl_lvl_s), .rise(scl_rise_s), .fall(scl_fall_s)
   );

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk(iCLK), .rst_n(iRST_N), .line_in(I2C_SDA),
      .level(sda_lvl_s), .rise(sda_rise_s), .fall(sda_fall_s)
   );

   assign I2C_SDA     = sda_oe_r ? 1'b0 : 1'bz;
   assign start_s     = sda_fall_s & scl_lvl_s;
   assign stop_s      = sda_rise_s & scl_lvl_s;
   assign in_byte_s   = {shift_r[6:0], sda_lvl_s};
   assign rd_byte_s   = regs_r[sub_r];
   assign last_rise_s = scl_rise_s && (bit_cnt_r == LAST_BIT);
   // bit_cnt is cleared by the 9th SCL rise, so a fall with count 0 ends the ACK slot
   assign ack_done_s  = scl_fall_s && (bit_cnt_r == 4'd0);

   // state register
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state;
      end
   end

   // next-state decode; START/STOP override every state
   always_comb begin
      next_state = state_r;
      if (stop_s) begin
         next_state = IDLE;
      end else if (start_s) begin
         next_state = ADDR;
      end else begin
         case (state_r)
            IDLE:      next_state = IDLE;
            ADDR: begin
               if (!last_rise_s)                           next_state = ADDR;
               else if (in_byte_s[BYTE_W-1:1] == DEV_ADDR) next_state = ADDR_ACK;
               else                                        next_state = IDLE;
            end
            ADDR_ACK: begin
               if (!ack_done_s) next_state = ADDR_ACK;
               else if (rw_r)   next_state = RD;
               else             next_state = SUB;
            end
            SUB:       next_state = last_rise_s ? SUB_ACK : SUB;
            SUB_ACK:   next_state = ack_done_s ? WR : SUB_ACK;
            WR:        next_state = last_rise_s ? WR_ACK : WR;
            WR_ACK:    next_state = ack_done_s ? WR : WR_ACK;
            RD:        next_state = last_rise_s ? RD_ACK : RD;
            RD_ACK: begin
               if (!ack_done_s) next_state = RD_ACK;
               else if (nack_r) next_state = IDLE_WAIT;
               else             next_state = RD;
            end
            IDLE_WAIT: next_state = IDLE_WAIT;
            default:   next_state = IDLE;
         endcase
      end
   end

   // datapath: shifter, counters, register file, SDA drive and host port
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         shift_r    <= 8'h00;
         sub_r      <= 8'h00;
         bit_cnt_r  <= 4'd0;
         rw_r       <= 1'b0;
         nack_r     <= 1'b0;
         sda_oe_r   <= 1'b0;
         wr_stb     <= 1'b0;
         wr_addr    <= 8'h00;
         wr_data    <= 8'h00;
         busy       <= 1'b0;
         host_rdata <= 8'h00;
         for (int i = 0; i < 256; i++) regs_r[i] <= 8'h00;
      end else begin
         wr_stb     <= 1'b0;
         host_rdata <= regs_r[host_addr];
         if (next_state == ADDR_ACK)  busy <= 1'b1;
         else if (next_state == IDLE) busy <= 1'b0;
         if (stop_s || start_s) begin
            sda_oe_r  <= 1'b0;
            bit_cnt_r <= 4'd0;
         end else begin
            case (state_r)
               ADDR, SUB, WR: begin
                  if (scl_rise_s) begin
                     shift_r <= in_byte_s;
                     if (bit_cnt_r == LAST_BIT) begin
                        bit_cnt_r <= ACK_BIT;
                        if (state_r == ADDR) rw_r  <= in_byte_s[RW_BIT];
                        if (state_r == SUB)  sub_r <= in_byte_s;
                        if (state_r == WR) begin
                           regs_r[sub_r] <= in_byte_s;
                           wr_stb        <= 1'b1;
                           wr_addr       <= sub_r;
                           wr_data       <= in_byte_s;
                           sub_r         <= sub_r + 8'd1;
                        end
                     end else begin
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                     end
                  end
               end
               ADDR_ACK, SUB_ACK, WR_ACK: begin
                  if (scl_rise_s) begin
                     bit_cnt_r <= 4'd0;
                  end else if (scl_fall_s && bit_cnt_r == ACK_BIT) begin
                     sda_oe_r <= 1'b1;
                  end else if (ack_done_s && state_r == ADDR_ACK && rw_r) begin
                     shift_r  <= rd_byte_s;
                     sda_oe_r <= ~rd_byte_s[7];
                  end else if (ack_done_s) begin
                     sda_oe_r <= 1'b0;
                  end
               end
               RD: begin
                  if (scl_rise_s) begin
                     bit_cnt_r <= (bit_cnt_r == LAST_BIT) ? ACK_BIT : bit_cnt_r + 4'd1;
                  end else if (scl_fall_s) begin
                     shift_r  <= {shift_r[6:0], shift_r[7]};
                     sda_oe_r <= ~shift_r[6];
                  end
               end
               RD_ACK: begin
                  if (scl_rise_s) begin
                     bit_cnt_r <= 4'd0;
                     nack_r    <= sda_lvl_s;
                     if (!sda_lvl_s) sub_r <= sub_r + 8'd1;
                  end else if (scl_fall_s && bit_cnt_r == ACK_BIT) begin
                     sda_oe_r <= 1'b0;
                  end else if (ack_done_s && !nack_r) begin
                     shift_r  <= rd_byte_s;
                     sda_oe_r <= ~rd_byte_s[7];
                  end else if (ack_done_s) begin
                     sda_oe_r <= 1'b0;
                  end
               end
               default: sda_oe_r <= 1'b0;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: bit-banged I2C master with open-drain SDA,
// host-port readback, and glitch / reset-during-ACK scenarios.
module tb_i2c_reg_target;
   localparam int Q = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       scl;
   logic       sda_low;
   logic [7:0] host_addr;
   logic [7:0] host_rdata;
   logic       wr_stb;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   wire        sda_bus;

   int checks = 0;
   int errors = 0;
   int stb_cnt = 0;
   int busy_cnt = 0;
   int drv_cnt = 0;
   logic [7:0] last_addr = 8'h00;
   logic [7:0] last_data = 8'h00;

   assign sda_bus = sda_low ? 1'b0 : 1'bz;
   pullup (sda_bus);

   always #5 clk = ~clk;

   i2c_reg_target dut (
      .iCLK(clk), .iRST_N(rst_n), .I2C_SCL(scl), .I2C_SDA(sda_bus),
      .host_addr(host_addr), .host_rdata(host_rdata),
      .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
   );

   // observe DUT activity on the inactive edge
   always @(negedge clk) begin
      if (wr_stb === 1'b1) begin
         stb_cnt   <= stb_cnt + 1;
         last_addr <= wr_addr;
         last_data <= wr_data;
      end
      if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
      if (sda_bus === 1'b0 && !sda_low) drv_cnt <= drv_cnt + 1;
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   task automatic wq(input int n);
      repeat (n) @(negedge clk);
   endtask

   // g: 0 none, 1 SDA glitch while SCL high, 2 SCL glitch while SCL low
   task automatic clk_bit(input logic v, input int g, output logic s);
      sda_low = ~v;
      wq(Q);
      if (g == 2) begin
         scl = 1'b1; wq(2); scl = 1'b0; wq(Q);
      end
      scl = 1'b1;
      wq(Q);
      s = sda_bus;
      if (g == 1) begin
         sda_low = ~sda_low; wq(2); sda_low = ~sda_low;
      end
      wq(Q);
      scl = 1'b0;
      wq(Q);
   endtask

   task automatic i2c_start();
      sda_low = 1'b0; wq(Q);
      scl = 1'b1;     wq(Q);
      sda_low = 1'b1; wq(Q);
      scl = 1'b0;     wq(Q);
   endtask

   task automatic i2c_stop();
      sda_low = 1'b1; wq(Q);
      scl = 1'b1;     wq(Q);
      sda_low = 1'b0; wq(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gpos, input int gtype, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], (i == gpos) ? gtype : 0, s);
      clk_bit(1'b1, 0, ack);
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, 0, s);
         b[i] = s;
      end
      clk_bit(nack, 0, s);
   endtask

   task automatic i2c_write(input logic [7:0] bt [6], input int n, output int nacks);
      logic a;
      nacks = 0;
      i2c_start();
      for (int i = 0; i < n; i++) begin
         send_byte(bt[i], -1, 0, a);
         if (a) nacks++;
      end
      i2c_stop();
      wq(Q);
   endtask

   task automatic host_rd(input logic [7:0] a, output logic [7:0] d);
      host_addr = a;
      wq(1);
      d = host_rdata;
   endtask

   initial begin
      logic       a;
      logic [7:0] d;
      logic [7:0] dv;
      logic [7:0] zero_tbl [8];
      int         n, b0, d0, s0;

      rst_n = 1'b0; scl = 1'b1; sda_low = 1'b0; host_addr = 8'h00;
      wq(4);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_sda", sda_bus, 1'b1);
      chk1("rst_wr_stb", wr_stb, 1'b0);
      chk8("rst_wr_addr", wr_addr, 8'h00);
      chk8("rst_wr_data", wr_data, 8'h00);
      chk8("rst_host_rdata", host_rdata, 8'h00);
      rst_n = 1'b1;
      wq(Q);

      // single write 0x98 <= 0x03
      i2c_start();
      send_byte(8'h72, -1, 0, a); chk1("t1_ack_dev", a, 1'b0);
      chk1("t1_busy", busy, 1'b1);
      send_byte(8'h98, -1, 0, a); chk1("t1_ack_sub", a, 1'b0);
      send_byte(8'h03, -1, 0, a); chk1("t1_ack_data", a, 1'b0);
      i2c_stop();
      wq(Q);
      chk8("t1_stb_cnt", 8'(stb_cnt), 8'd1);
      chk8("t1_wr_addr", last_addr, 8'h98);
      chk8("t1_wr_data", last_data, 8'h03);
      chk1("t1_busy_end", busy, 1'b0);
      host_rd(8'h98, d); chk8("t1_host_98", d, 8'h03);

      // burst with sub-address wrap
      i2c_write('{8'h72, 8'hFE, 8'hAA, 8'hBB, 8'hCC, 8'h00}, 5, n);
      chk8("t2_nacks", 8'(n), 8'd0);
      chk8("t2_stb_cnt", 8'(stb_cnt), 8'd4);
      chk8("t2_last_addr", last_addr, 8'h00);
      chk8("t2_last_data", last_data, 8'hCC);
      host_rd(8'hFE, d); chk8("t2_host_FE", d, 8'hAA);
      host_rd(8'hFF, d); chk8("t2_host_FF", d, 8'hBB);
      host_rd(8'h00, d); chk8("t2_host_00", d, 8'hCC);

      // preload 0x41/0x42, then read back through repeated START
      i2c_write('{8'h72, 8'h41, 8'h10, 8'h5A, 8'h00, 8'h00}, 4, n);
      chk8("t3_preload_nacks", 8'(n), 8'd0);
      i2c_start();
      send_byte(8'h72, -1, 0, a); chk1("t3_ack_dev", a, 1'b0);
      send_byte(8'h41, -1, 0, a); chk1("t3_ack_sub", a, 1'b0);
      i2c_start();
      send_byte(8'h73, -1, 0, a); chk1("t3_ack_rd", a, 1'b0);
      recv_byte(1'b0, d); chk8("t3_rd0", d, 8'h10);
      recv_byte(1'b1, d); chk8("t3_rd1", d, 8'h5A);
      wq(Q);
      chk1("t3_sda_released", sda_bus, 1'b1);
      i2c_stop();
      wq(Q);
      chk8("t3_stb_cnt", 8'(stb_cnt), 8'd6);

      // wrong device address
      b0 = busy_cnt; d0 = drv_cnt; s0 = stb_cnt;
      i2c_start();
      send_byte(8'h74, -1, 0, a); chk1("t4_nack_dev", a, 1'b1);
      send_byte(8'h55, -1, 0, a); chk1("t4_nack_data", a, 1'b1);
      i2c_stop();
      wq(Q);
      chk8("t4_busy_cycles", 8'(busy_cnt - b0), 8'd0);
      chk8("t4_sda_driven", 8'(drv_cnt - d0), 8'd0);
      chk8("t4_stb", 8'(stb_cnt - s0), 8'd0);

      // partial byte then full write to 0x20
      i2c_start();
      send_byte(8'h72, -1, 0, a); chk1("t5_ack_dev", a, 1'b0);
      send_byte(8'h20, -1, 0, a); chk1("t5_ack_sub", a, 1'b0);
      clk_bit(1'b1, 0, a); clk_bit(1'b0, 0, a); clk_bit(1'b1, 0, a); clk_bit(1'b0, 0, a);
      i2c_stop();
      wq(Q);
      chk8("t5_partial_stb", 8'(stb_cnt), 8'd6);
      host_rd(8'h20, d); chk8("t5_partial_reg", d, 8'h00);
      i2c_write('{8'h72, 8'h20, 8'h77, 8'h00, 8'h00, 8'h00}, 3, n);
      chk8("t5_nacks", 8'(n), 8'd0);
      chk8("t5_stb", 8'(stb_cnt), 8'd7);
      host_rd(8'h20, d); chk8("t5_reg20", d, 8'h77);

      // short glitches on both lines must be ignored
      i2c_start();
      send_byte(8'h72, -1, 0, a); chk1("tg_ack_dev", a, 1'b0);
      send_byte(8'h31, 5, 2, a);  chk1("tg_ack_sub", a, 1'b0);
      send_byte(8'hC5, 7, 1, a);  chk1("tg_ack_data", a, 1'b0);
      i2c_stop();
      wq(Q);
      chk8("tg_stb", 8'(stb_cnt), 8'd8);
      chk8("tg_last_addr", last_addr, 8'h31);
      host_rd(8'h31, d); chk8("tg_reg31", d, 8'hC5);

      // reset while the target is holding the address ACK
      dv = 8'h72;
      i2c_start();
      for (int i = 7; i >= 0; i--) clk_bit(dv[i], 0, a);
      sda_low = 1'b0;
      wq(1);
      chk1("t6_ack_driven", sda_bus, 1'b0);
      rst_n = 1'b0;
      wq(1);
      chk1("t6_sda_released", sda_bus, 1'b1);
      chk1("t6_busy", busy, 1'b0);
      chk8("t6_wr_addr", wr_addr, 8'h00);
      wq(3);
      rst_n = 1'b1;
      wq(2 * Q);
      zero_tbl = '{8'h98, 8'hFE, 8'hFF, 8'h00, 8'h41, 8'h42, 8'h20, 8'h31};
      for (int i = 0; i < 8; i++) begin
         host_rd(zero_tbl[i], d);
         chk8("t6_reg_cleared", d, 8'h00);
      end
      send_byte(8'h72, -1, 0, a); chk1("t6_idle_no_start", a, 1'b1);
      i2c_stop();
      wq(Q);
      i2c_write('{8'h72, 8'h05, 8'h9C, 8'h00, 8'h00, 8'h00}, 3, n);
      chk8("t6_nacks", 8'(n), 8'd0);
      chk8("t6_stb", 8'(stb_cnt), 8'd9);
      host_rd(8'h05, d); chk8("t6_reg05", d, 8'h9C);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
